// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// big-endian lane helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Big-endian lane offsets: offset 0 is the most significant lane.
   localparam logic [1:0] OFF_BYTE0   = 2'd0;
   localparam logic [1:0] OFF_BYTE3   = 2'd3;
   localparam logic [1:0] OFF_HALF_HI = 2'd0;
   localparam logic [1:0] OFF_HALF_LO = 2'd2;

   // Bit position of the least significant bit of a byte lane.
   function automatic logic [4:0] byte_lsb(input logic [1:0] offset);
      return {~offset, 3'b000};
   endfunction

   // Bit position of the least significant bit of a halfword lane.
   function automatic logic [4:0] half_lsb(input logic [1:0] offset);
      return (offset == OFF_HALF_HI) ? 5'd16 : 5'd0;
   endfunction

   // Number of bytes touched by an access; zero for the illegal encoding.
   function automatic logic [2:0] size_bytes(input size_e size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational big-endian lane steering: extracts and extends a load value
// and merges right-justified store data into a memory word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] merged_word
);

   logic [4:0]  lsb;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case statement can infer a latch.
   always_comb begin
      lsb         = '0;
      byte_val    = '0;
      half_val    = '0;
      load_value  = '0;
      merged_word = word;
      case (size)
         SZ_BYTE: begin
            lsb         = byte_lsb(offset);
            byte_val    = word[lsb +: 8];
            load_value  = {{24{~is_unsigned & byte_val[7]}}, byte_val};
            merged_word = (word & ~(32'h0000_00FF << lsb))
                        | ({24'b0, store_data[7:0]} << lsb);
         end
         SZ_HALF: begin
            lsb         = half_lsb(offset);
            half_val    = word[lsb +: 16];
            load_value  = {{16{~is_unsigned & half_val[15]}}, half_val};
            merged_word = (word & ~(32'h0000_FFFF << lsb))
                        | ({16'b0, store_data[15:0]} << lsb);
         end
         SZ_WORD: begin
            load_value  = word;
            merged_word = store_data;
         end
         default: begin
            load_value  = '0;
            merged_word = word;
         end
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only big-endian data memory; sub-word
// stores are performed as read-modify-write, one transaction in flight.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_e            state_q, state_d;
   logic              accept;
   size_e             req_size_e;
   logic              req_err;
   logic              misaligned;
   logic              out_of_range;
   logic [ADDR_W:0]   access_end;
   logic [ADDR_W:0]   access_len;

   logic              write_q;
   logic              unsigned_q;
   size_e             size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       wbuf_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0]       load_value;
   logic [31:0]       merged_word;

   assign req_size_e = size_e'(req_size);
   assign accept     = req_valid && (state_q == ST_IDLE);

   // Request checks run on the live inputs so the error is known at accept.
   always_comb begin
      access_len      = '0;
      access_len[2:0] = size_bytes(req_size_e);
      access_end      = {1'b0, req_addr} + access_len;
      out_of_range    = access_end > (ADDR_W + 1)'(MEM_BYTES);
      misaligned      = ((req_size_e == SZ_HALF) && req_addr[0])
                     || ((req_size_e == SZ_WORD) && (req_addr[1:0] != 2'b00));
      req_err         = (req_size_e == SZ_BAD) || misaligned || out_of_range;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_err)
                  state_d = ST_DONE;
               else if (req_write && (req_size_e == SZ_WORD))
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ:  state_d = write_q ? ST_WRITE : ST_DONE;
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = resp_ready ? ST_IDLE : ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state is assigned with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= SZ_BYTE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wbuf_q     <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size_e;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            // Word stores skip READ, so the buffer is loaded straight away.
            wbuf_q     <= req_wdata;
            rdata_q    <= '0;
            err_q      <= req_err;
         end else if (state_q == ST_READ) begin
            if (write_q)
               wbuf_q <= merged_word;
            else
               rdata_q <= load_value;
         end
      end
   end

   lsu_lane_align u_align (
      .word        (mem_rdata),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .store_data  (wdata_q),
      .load_value  (load_value),
      .merged_word (merged_word)
   );

   // Handshake and write strobe come from the state register alone; the
   // asynchronous reset clears it, which drops mem_write at once.
   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign mem_write  = (state_q == ST_WRITE);
   assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata  = wbuf_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: directed requests push expected responses,
// a negedge monitor pops and compares them against the DUT.
module tb_lsu_rmw;
   import lsu_pkg::*;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned MEM_BYTES = 1024;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_unsigned = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b1;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0]       mem [0:255];
   int unsigned       cyc = 0;
   int                n_checks = 0;
   int                n_fail = 0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int unsigned lat;
      logic        wr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      int unsigned acc;
   } exp_t;

   exp_t sb[$];

   lsu_rmw #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Word-wide data memory with combinational read.
   assign mem_rdata = mem[mem_addr[9:2]];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]   <= 32'h80A1_B2C3;
      mem[12]  <= 32'h1122_3344;
      mem[255] <= 32'h1234_56A5;
      forever begin
         @(posedge clk);
         if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: write strobes and responses are checked against the queue head.
   logic        mon_seen = 1'b0;
   int unsigned mon_wr_cnt = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_seen   = 1'b0;
            mon_wr_cnt = 0;
         end else begin
            if (mem_write) begin
               mon_wr_cnt++;
               if (sb.size() == 0) begin
                  check("write with nothing in flight", {31'b0, mem_write}, 32'h0);
               end else begin
                  check({sb[0].name, " write allowed"}, {31'b0, mem_write}, {31'b0, sb[0].wr});
                  check({sb[0].name, " mem_addr"}, mem_addr, sb[0].waddr);
                  check({sb[0].name, " mem_wdata"}, mem_wdata, sb[0].wdata);
               end
            end
            if (resp_valid && !mon_seen) begin
               mon_seen = 1'b1;
               if (sb.size() == 0) begin
                  check("response with nothing in flight", {31'b0, resp_valid}, 32'h0);
               end else begin
                  e = sb.pop_front();
                  check({e.name, " rdata"}, resp_rdata, e.rdata);
                  check({e.name, " err"}, {31'b0, resp_err}, {31'b0, e.err});
                  check({e.name, " latency"}, cyc - e.acc + 1, e.lat);
                  check({e.name, " write count"}, mon_wr_cnt, e.wr ? 32'd1 : 32'd0);
               end
               mon_wr_cnt = 0;
            end
            if (!resp_valid) mon_seen = 1'b0;
         end
      end
   end

   task automatic wait_idle(input string name);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(sb.size() == 0 && !resp_valid) && t < 30);
      if (t >= 30) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: response timeout, %0d entries still pending", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int unsigned lat, input logic exp_wr,
                        input logic [31:0] exp_wdata, input bit wait_done);
      exp_t e;
      int   t = 0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         check({name, " accept"}, {31'b0, req_ready}, 32'h1);
         req_valid = 1'b0;
         return;
      end
      e.name  = name;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = lat;
      e.wr    = exp_wr;
      e.waddr = {addr[31:2], 2'b00};
      e.wdata = exp_wdata;
      e.acc   = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (wait_done) wait_idle(name);
   endtask

   initial begin
      int t;

      // Reset state
      @(negedge clk);
      check("reset req_ready", {31'b0, req_ready}, 32'h1);
      check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
      check("reset resp_rdata", resp_rdata, 32'h0);
      check("reset resp_err", {31'b0, resp_err}, 32'h0);
      check("reset mem_write", {31'b0, mem_write}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Loads with sign/zero extension
      issue("lb 0x10",  0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFF_FF80, 0, 2, 0, 32'h0, 1);
      issue("lbu 0x10", 0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_0080, 0, 2, 0, 32'h0, 1);
      issue("lh 0x12",  0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_B2C3, 0, 2, 0, 32'h0, 1);
      issue("lhu 0x12", 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_B2C3, 0, 2, 0, 32'h0, 1);

      // Sub-word and word stores
      issue("sb 0x11",  1, 2'b00, 0, 32'h11, 32'h0000_00EE, 32'h0, 0, 3, 1, 32'h80EE_B2C3, 1);
      issue("lw 0x10",  0, 2'b10, 0, 32'h10, 32'h0, 32'h80EE_B2C3, 0, 2, 0, 32'h0, 1);
      issue("sw 0x20",  1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 32'hDEAD_BEEF, 1);
      issue("lw 0x20",  0, 2'b10, 0, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 32'h0, 1);
      issue("sh 0x22",  1, 2'b01, 0, 32'h22, 32'hFFFF_1234, 32'h0, 0, 3, 1, 32'hDEAD_1234, 1);
      issue("lh 0x22",  0, 2'b01, 0, 32'h22, 32'h0, 32'h0000_1234, 0, 2, 0, 32'h0, 1);

      // Last byte of memory is legal
      issue("lbu 0x3FF", 0, 2'b00, 1, 32'h3FF, 32'h0, 32'h0000_00A5, 0, 2, 0, 32'h0, 1);
      issue("lb 0x3FF",  0, 2'b00, 0, 32'h3FF, 32'h0, 32'hFFFF_FFA5, 0, 2, 0, 32'h0, 1);

      // Error responses
      issue("lh 0x11 misaligned",  0, 2'b01, 0, 32'h11,  32'h0, 32'h0, 1, 1, 0, 32'h0, 1);
      issue("sw 0x22 misaligned",  1, 2'b10, 0, 32'h22,  32'hCAFE_F00D, 32'h0, 1, 1, 0, 32'h0, 1);
      issue("lw 0x3FE range",      0, 2'b10, 0, 32'h3FE, 32'h0, 32'h0, 1, 1, 0, 32'h0, 1);
      issue("lb 0x400 range",      0, 2'b00, 0, 32'h400, 32'h0, 32'h0, 1, 1, 0, 32'h0, 1);
      issue("size 11 load",        0, 2'b11, 0, 32'h10,  32'h0, 32'h0, 1, 1, 0, 32'h0, 1);
      issue("size 11 store",       1, 2'b11, 0, 32'h10,  32'h5555_5555, 32'h0, 1, 1, 0, 32'h0, 1);

      // Back-pressure in DONE with a stray request that must be ignored
      resp_ready = 1'b0;
      issue("lw stall", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80EE_B2C3, 0, 2, 0, 32'h0, 0);
      t = 0;
      while (!resp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 3; i++) begin
         check("stall resp_valid", {31'b0, resp_valid}, 32'h1);
         check("stall resp_rdata", resp_rdata, 32'h80EE_B2C3);
         check("stall req_ready", {31'b0, req_ready}, 32'h0);
         if (i == 0) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h20;
            req_wdata = 32'h0BAD_0BAD;
         end
         if (i == 1) req_valid = 1'b0;
         if (i == 2) resp_ready = 1'b1;
         @(negedge clk);
      end
      check("post-stall resp_valid", {31'b0, resp_valid}, 32'h0);
      check("post-stall req_ready", {31'b0, req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      check("stray request ignored", {31'b0, resp_valid}, 32'h0);
      check("stray store not written", mem[8], 32'hDEAD_1234);

      // Reset during WRITE of a sub-word store
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = 1'b1;
      req_size     = 2'b01;
      req_unsigned = 1'b0;
      req_addr     = 32'h30;
      req_wdata    = 32'h0000_ABCD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 check("rst sh write strobe", {31'b0, mem_write}, 32'h1);
      check("rst sh merged word", mem_wdata, 32'hABCD_3344);
      #1 reset = 1'b1;
      #1 check("rst drops mem_write", {31'b0, mem_write}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst mem 0x30 unchanged", mem[12], 32'h1122_3344);
      check("rst req_ready", {31'b0, req_ready}, 32'h1);
      check("rst resp_valid", {31'b0, resp_valid}, 32'h0);
      check("rst resp_err", {31'b0, resp_err}, 32'h0);
      issue("lw 0x30 after reset", 0, 2'b10, 0, 32'h30, 32'h0, 32'h1122_3344, 0, 2, 0, 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
